// File: rtl/tt_um_vedic_mult_4x4.sv
// tt_um_vedic_mult_4x4: registered unsigned 4x4 Vedic multiplier tile
module vedic_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module vedic_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  assign p[0] = a[0] & b[0];
  vedic_ha h0 (.a(a[1] & b[0]), .b(a[0] & b[1]), .s(p[1]), .c(c1));
  vedic_ha h1 (.a(a[1] & b[1]), .b(c1), .s(p[2]), .c(p[3]));
endmodule

module vedic_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  logic [W-1:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < W - 1; i++) begin : g_fa
    vedic_fa f (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign s[W-1] = a[W-1] ^ b[W-1] ^ c[W-1];
endmodule

module tt_um_vedic_mult_4x4 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  logic [3:0] q0, q1, q2, q3;
  logic [4:0] s1;
  logic [5:0] s2;
  logic       unused_ok;
  vedic_2x2 m0 (.a(ui_in[5:4]), .b(ui_in[1:0]), .p(q0));
  vedic_2x2 m1 (.a(ui_in[7:6]), .b(ui_in[1:0]), .p(q1));
  vedic_2x2 m2 (.a(ui_in[5:4]), .b(ui_in[3:2]), .p(q2));
  vedic_2x2 m3 (.a(ui_in[7:6]), .b(ui_in[3:2]), .p(q3));
  vedic_rca #(.W(5)) a1 (.a({1'b0, q1}), .b({1'b0, q2}), .s(s1));
  vedic_rca #(.W(6)) a2 (.a({1'b0, s1}), .b({q3, q0[3:2]}), .s(s2));
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{ena, uio_in, 1'b0};
  // product register, cleared asynchronously while rst_n is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) uo_out <= 8'h00;
    else        uo_out <= {s2, q0[1:0]};
endmodule

// File: tb/tb_tt_um_vedic_mult_4x4.sv
// tb_tt_um_vedic_mult_4x4: scoreboard bench for the Vedic multiplier tile
module tb_tt_um_vedic_mult_4x4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] sb[$];
  int         total = 0;
  int         passed = 0;

  tt_um_vedic_mult_4x4 dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_uio(input string tag);
    chk({tag, "_uio_out"}, uio_out, 8'h00);
    chk({tag, "_uio_oe"}, uio_oe, 8'h00);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] e;
    e = 8'(a) * 8'(b);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    ui_in = {a, b};
    push(a, b);
  endtask

  task automatic sample(input string tag);
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, uo_out);
    end else begin
      e = sb.pop_front();
      chk(tag, uo_out, e);
    end
  endtask

  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b);
    drive(a, b);
    sample(tag);
    push(a, b);
    sample({tag, "_hold"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    uio_in = 8'h00;
    ui_in = 8'h32;
    #1;
    chk("reset_t0", uo_out, 8'h00);
    chk_uio("reset_t0");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", uo_out, 8'h00);
      chk_uio("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply("mul_3x2", 4'd3, 4'd2);
    apply("mul_5x4", 4'd5, 4'd4);
    apply("mul_15x15", 4'd15, 4'd15);
    apply("mul_9x0", 4'd9, 4'd0);
    apply("mul_1x13", 4'd1, 4'd13);
    drive(4'd5, 4'd4);
    sample("lat_pre");
    @(negedge clk);
    ui_in = {4'd15, 4'd15};
    #1;
    chk("lat_midcycle", uo_out, 8'd20);
    push(4'd15, 4'd15);
    sample("lat_edge");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", uo_out, 8'h00);
    chk_uio("async_clear");
    ui_in = {4'd7, 4'd3};
    #1;
    chk("async_hold", uo_out, 8'h00);
    rst_n = 1'b1;
    push(4'd7, 4'd3);
    sample("post_reset_load");
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ui_in = 8'(i);
      ena = 1'($urandom_range(0, 1));
      push(4'(i >> 4), 4'(i));
      sample("exhaustive");
      chk_uio("exhaustive");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tt_um_vedic_mult_4x4.md
Name: tt_um_vedic_mult_4x4

Overview:
- TinyTapeout user tile: an unsigned 4x4-bit multiplier built on Vedic (Urdhva Tiryagbhyam) decomposition.
- Both operands are packed on the dedicated input bus `ui_in`; the 8-bit product is driven on `uo_out`.
- The product register is clocked by the tile's single clock.
- The bidirectional pins are unused and held as inputs.

Parameters:
- None. Widths are fixed: 4-bit operands, 8-bit product.

Ports:
- `clk`  input  1  tile clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `ena`  input  1  tile enable from the TinyTapeout harness; has no functional effect.
- `ui_in`  input  8  operands: A = `ui_in[7:4]`, B = `ui_in[3:0]`, both unsigned.
- `uo_out`  output  8  registered product A*B, unsigned.
- `uio_in`  input  8  unused, ignored.
- `uio_out`  output  8  constant 8'h00.
- `uio_oe`  output  8  constant 8'h00 (all bidirectional pins are inputs).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset:
  - While `rst_n`=0, the product register is forced to 8'h00 immediately, without waiting for a clock edge.
  - `uo_out` reads 0 during reset.
  - On deassertion, the register first loads at the next rising `clk` edge.
  - Reset asserted mid-operation clears `uo_out` asynchronously. The in-flight product is discarded.
- Combinational core, Vedic 4x4:
  - Split operands into halves: AH = A[3:2], AL = A[1:0], BH = B[3:2], BL = B[1:0].
  - Four 2x2 Vedic multipliers: Q0 = AL*BL, Q1 = AH*BL, Q2 = AL*BH, Q3 = AH*BH, each 4 bits wide.
  - Each 2x2 block is built from AND gates plus two half adders:
    - p0 = a0&b0
    - p1 = (a1&b0) XOR (a0&b1), carry c1
    - p2 and p3 from (a1&b1) + c1
  - Combination:
    - P[1:0] = Q0[1:0]
    - S1 = Q1 + Q2 (5 bits)
    - S2 = S1 + {Q3, Q0[3:2]} (6 bits, aligned)
    - P[7:2] = S2
  - All adders are built from half/full adder cells, not from the `*` operator.
  - Any equivalent ripple/adder arrangement is acceptable provided the result is bit-exact A*B.
- Register and latency:
  - At each rising `clk` edge with `rst_n`=1, `uo_out` <= A*B of the current `ui_in`.
  - Latency is 1 clock: a value applied before edge N appears on `uo_out` just after edge N.
  - Output is held constant between edges.
  - No handshake: a new operand pair is accepted every cycle.
- Arithmetic:
  - Unsigned throughout.
  - Maximum product 15*15 = 225 (8'hE1) fits in 8 bits; no overflow is possible.
  - Any operand equal to 0 yields 0. 1*X yields X.
- `ena`:
  - Ignored; the register updates regardless of `ena`.
- Bidirectional outputs:
  - `uio_out` and `uio_oe` are constant zero in every state, including reset.
- X-handling:
  - No internal state other than the 8-bit product register.
  - Outputs are defined from reset onward.

Test Plan:
- Reset:
  - Stimulus: hold `rst_n`=0 for 2 cycles with `ui_in`=8'h32.
  - Required: `uo_out`=0 throughout.
  - Required: `uio_out`=0 and `uio_oe`=0 throughout.
- Basic products (apply with `rst_n`=1, each for 2 clock periods, `uo_out` checked one edge after the change):
  - `ui_in`={3,2} -> `uo_out`=6.
  - `ui_in`={5,4} -> `uo_out`=20 (8'h14).
  - `ui_in`={15,15} -> `uo_out`=225 (8'hE1), max case with full carry propagation.
  - `ui_in`={9,0} -> `uo_out`=0.
- Latency:
  - Stimulus: change `ui_in` from {5,4} to {15,15} mid-cycle.
  - Required: `uo_out` stays 20 until the next rising edge, then becomes 225.
- Async reset mid-run:
  - Stimulus: with `uo_out`=225, pull `rst_n` low between edges.
  - Required: `uo_out` goes to 0 without a clock edge.
  - Stimulus: release `rst_n`.
  - Required: the next edge loads the product of the current `ui_in`.
- Exhaustive:
  - Stimulus: all 256 (A,B) pairs, one per cycle.
  - Required: `uo_out` equals A*B one edge later for every pair.
  - Required: `uio_out`/`uio_oe` remain 0 throughout.
  - Required: toggling `ena` has no effect.
